// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and default bit timing.
package uart_pkg;

  // 50 MHz system clock, 115200 baud.
  localparam int unsigned CLKS_PER_BIT_DEF = 434;
  localparam int unsigned DATA_BITS        = 8;

  typedef enum logic [2:0] {
    IDLE_S  = 3'b000,
    START_S = 3'b001,
    DATA_S  = 3'b010,
    STOP_S  = 3'b011,
    DONE_S  = 3'b100,
    ERR_S   = 3'b101
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_core_if.sv
// Receiver-side signal bundle: serial input plus received-data status.
interface uart_rx_core_if;

  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       rx_busy_o;
  logic [2:0] rx_state_o;

  // Receiver core: consumes the line, produces data and status.
  modport master (
    input  rx_i,
    output rx_data_o, rx_valid_o, frame_err_o, rx_busy_o, rx_state_o
  );

  // Line driver / data consumer side.
  modport slave (
    output rx_i,
    input  rx_data_o, rx_valid_o, frame_err_o, rx_busy_o, rx_state_o
  );

endinterface

// File: rtl/uart_rx_fsm.sv
// 8N1 receiver control: state register, registered status pulses and the
// strobes that steer the baud counter, bit index and shift register.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxs,
  input  logic [15:0]    baud_cnt,
  input  logic           last_bit,
  output uart_rx_state_e state,
  output logic           cnt_clr,
  output logic           cnt_en,
  output logic           idx_clr,
  output logic           shift_en,
  output logic           data_load,
  output logic           rx_valid,
  output logic           frame_err
);

  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  logic half_hit;
  logic bit_hit;

  assign half_hit = (baud_cnt == HALF_LAST);
  assign bit_hit  = (baud_cnt == BIT_LAST);

  // Control decodes; counter clear takes priority over increment in the core.
  assign cnt_en    = (state == START_S) || (state == DATA_S) || (state == STOP_S);
  assign idx_clr   = (state == START_S) && half_hit && !rxs;
  assign shift_en  = (state == DATA_S) && bit_hit;
  assign data_load = (state == STOP_S) && bit_hit && rxs;
  assign cnt_clr   = ((state == IDLE_S) && !rxs) || idx_clr || shift_en;

  // State transitions plus single-cycle valid / framing-error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE_S;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge; the pulse defaults below are then
      // overridden only on the transition that enters DONE_S or ERR_S.
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE_S:  if (!rxs) state <= START_S;
        START_S: if (half_hit) state <= rxs ? IDLE_S : DATA_S;
        DATA_S:  if (bit_hit && last_bit) state <= STOP_S;
        STOP_S: begin
          if (bit_hit) begin
            if (rxs) begin
              state    <= DONE_S;
              rx_valid <= 1'b1;
            end else begin
              state     <= ERR_S;
              frame_err <= 1'b1;
            end
          end
        end
        DONE_S:  state <= IDLE_S;
        ERR_S:   if (rxs) state <= IDLE_S;
        default: state <= IDLE_S;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchronizer, baud counter, bit index, shift
// register and output byte register around the uart_rx_fsm controller.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_core_if.master  bus
);

  logic           rx_meta;
  logic           rxs;
  logic [15:0]    baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift_reg;
  logic [7:0]     rx_data;
  uart_rx_state_e state;
  logic           cnt_clr;
  logic           cnt_en;
  logic           idx_clr;
  logic           shift_en;
  logic           data_load;
  logic           rx_valid;
  logic           frame_err;

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: reset to the idle line level so leaving reset never looks
      // like a start-bit falling edge.
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx_i;
      rxs     <= rx_meta;
    end
  end

  // Baud counter: cleared at each bit boundary, counts while receiving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         baud_cnt <= '0;
    else if (cnt_clr) baud_cnt <= '0;
    else if (cnt_en)  baud_cnt <= baud_cnt + 16'd1;
  end

  // Data bit index; wraps 7->0 after the eighth sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           bit_idx <= '0;
    else if (idx_clr)  bit_idx <= '0;
    else if (shift_en) bit_idx <= bit_idx + 3'd1;
  end

  // LSB-first shift register: each mid-bit sample enters at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           shift_reg <= '0;
    else if (shift_en) shift_reg <= {rxs, shift_reg[7:1]};
  end

  // Output byte: updated only when a frame ends with a good stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rx_data <= '0;
    else if (data_load) rx_data <= shift_reg;
  end

  uart_rx_fsm #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .HALF_BIT     (HALF_BIT)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .rxs       (rxs),
    .baud_cnt  (baud_cnt),
    .last_bit  (bit_idx == 3'd7),
    .state     (state),
    .cnt_clr   (cnt_clr),
    .cnt_en    (cnt_en),
    .idx_clr   (idx_clr),
    .shift_en  (shift_en),
    .data_load (data_load),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  assign bus.rx_data_o   = rx_data;
  assign bus.rx_valid_o  = rx_valid;
  assign bus.frame_err_o = frame_err;
  assign bus.rx_busy_o   = (state != IDLE_S);
  assign bus.rx_state_o  = state;

endmodule
